// File: rtl/haar_dwt.sv
// haar_dwt: single-level Haar DWT over a streamed window of SIGNAL_LENGTH samples.
// Samples shift in while idle; a start pulse freezes the window and emits
// SIGNAL_LENGTH/2 approximation/detail pairs, one per clock, with done on the last.
// Optional build macro: HAAR_DWT_ROUND_EN selects round-half-up coefficients
// instead of the default truncating ones.
module haar_dwt #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned SIGNAL_LENGTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_d,
    output logic                  done
);

    localparam int unsigned NPAIRS = SIGNAL_LENGTH / 2;
    localparam int unsigned KW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int unsigned EW     = DATA_WIDTH + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [DATA_WIDTH-1:0] samp_q [SIGNAL_LENGTH];
    logic [DATA_WIDTH-1:0] samp_d [SIGNAL_LENGTH];
    logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
    logic [DATA_WIDTH-1:0] dout_d_q, dout_d_d;
    logic                  done_q, done_d;

    logic [KW:0]           idx_a_c, idx_b_c;
    logic [DATA_WIDTH-1:0] a_c, b_c;
    logic [EW-1:0]         sum_c;
    logic signed [EW-1:0]  diff_c;

    // Select pair k from the frozen window and form the extended sum/difference.
    always_comb begin
        idx_a_c = {k_q, 1'b0};
        idx_b_c = {k_q, 1'b1};
        a_c     = samp_q[idx_a_c];
        b_c     = samp_q[idx_b_c];
`ifdef HAAR_DWT_ROUND_EN
        sum_c   = EW'({1'b0, a_c}) + EW'({1'b0, b_c}) + EW'(1);
        diff_c  = $signed(EW'({1'b0, a_c})) - $signed(EW'({1'b0, b_c})) + $signed(EW'(1));
`else
        sum_c   = EW'({1'b0, a_c}) + EW'({1'b0, b_c});
        diff_c  = $signed(EW'({1'b0, a_c})) - $signed(EW'({1'b0, b_c}));
`endif
    end

    // Next-state: shift samples while idle, emit one pair per clock while busy.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        samp_d   = samp_q;
        dout_a_d = dout_a_q;
        dout_d_d = dout_d_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    k_d     = '0;
                end else begin
                    for (int unsigned i = 0; i < SIGNAL_LENGTH - 1; i++) begin
                        samp_d[i] = samp_q[i+1];
                    end
                    samp_d[SIGNAL_LENGTH-1] = din;
                end
            end
            BUSY: begin
                dout_a_d = DATA_WIDTH'(sum_c >> 1);
                dout_d_d = DATA_WIDTH'(diff_c >>> 1);
                if (k_q == KW'(NPAIRS - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            dout_a_q <= '0;
            dout_d_q <= '0;
            done_q   <= 1'b0;
            for (int unsigned i = 0; i < SIGNAL_LENGTH; i++) begin
                samp_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            dout_a_q <= dout_a_d;
            dout_d_q <= dout_d_d;
            done_q   <= done_d;
            for (int unsigned i = 0; i < SIGNAL_LENGTH; i++) begin
                samp_q[i] <= samp_d[i];
            end
        end
    end

    assign dout_a = dout_a_q;
    assign dout_d = dout_d_q;
    assign done   = done_q;

endmodule

// File: tb/tb_haar_dwt.sv
// tb_haar_dwt: directed and random stimulus against a queue-based Haar model.
module tb_haar_dwt;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 8;

`ifdef HAAR_DWT_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          start;
    logic [DW-1:0] dout_a;
    logic [DW-1:0] dout_d;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Reference model: sample window plus a queue of pending coefficient pairs.
    int mx [N];
    int q_a[$];
    int q_d[$];
    int ea = 0, ed = 0, edone = 0;

    haar_dwt #(.DATA_WIDTH(DW), .SIGNAL_LENGTH(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .start (start),
        .dout_a(dout_a),
        .dout_d(dout_d),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Coefficients from 9-bit wrapped arithmetic: bits [8:1] of the extended value.
    function automatic int coef_a(input int a, input int b);
        return ((a + b + RND) & 'h1FF) >> 1;
    endfunction

    function automatic int coef_d(input int a, input int b);
        return ((a - b + RND) & 'h1FF) >> 1;
    endfunction

    // One clock: drive, advance the model, compare all outputs.
    task automatic cyc(input logic r, input logic s, input int d);
        rst   = r;
        start = s;
        din   = DW'(d);
        @(posedge clk);
        if (!r) begin
            foreach (mx[i]) mx[i] = 0;
            q_a.delete();
            q_d.delete();
            ea = 0; ed = 0; edone = 0;
        end else if (q_a.size() > 0) begin
            ea    = q_a.pop_front();
            ed    = q_d.pop_front();
            edone = (q_a.size() == 0) ? 1 : 0;
        end else if (s) begin
            for (int k = 0; k < int'(N / 2); k++) begin
                q_a.push_back(coef_a(mx[2*k], mx[2*k+1]));
                q_d.push_back(coef_d(mx[2*k], mx[2*k+1]));
            end
            edone = 0;
        end else begin
            for (int i = 0; i < int'(N) - 1; i++) mx[i] = mx[i+1];
            mx[N-1] = d;
            edone = 0;
        end
        #1;
        check_eq("dout_a", int'(dout_a), ea);
        check_eq("dout_d", int'(dout_d), ed);
        check_eq("done", int'(done), edone);
    endtask

    task automatic load(input int v0, input int v1, input int v2, input int v3,
                        input int v4, input int v5, input int v6, input int v7);
        cyc(1, 0, v0); cyc(1, 0, v1); cyc(1, 0, v2); cyc(1, 0, v3);
        cyc(1, 0, v4); cyc(1, 0, v5); cyc(1, 0, v6); cyc(1, 0, v7);
    endtask

    int ramp_a [4];
    int ramp_d [4];
    int ndone;

    initial begin
`ifdef HAAR_DWT_ROUND_EN
        ramp_a = '{1, 3, 5, 7};
        ramp_d = '{0, 0, 0, 0};
`else
        ramp_a = '{0, 2, 4, 6};
        ramp_d = '{'hFF, 'hFF, 'hFF, 'hFF};
`endif
        // Reset state
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check_eq("rst_a", int'(dout_a), 0);
        check_eq("rst_done", int'(done), 0);

        // Ramp with explicit expected pairs, then a back-to-back repeat
        for (int i = 0; i < 8; i++) cyc(1, 0, i);
        cyc(1, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0);
            check_eq("ramp_a", int'(dout_a), ramp_a[k]);
            check_eq("ramp_d", int'(dout_d), ramp_d[k]);
            check_eq("ramp_done", int'(done), (k == 3) ? 1 : 0);
        end
        cyc(1, 1, 0);
        check_eq("b2b_done_low", int'(done), 0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0);
            check_eq("b2b_a", int'(dout_a), ramp_a[k]);
            check_eq("b2b_done", int'(done), (k == 3) ? 1 : 0);
        end

        // Extremes: sum must not overflow
        load(255, 255, 0, 255, 255, 0, 128, 128);
        cyc(1, 1, 0);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0);

        // din present on the start edge is not captured
        load(1, 2, 3, 4, 5, 6, 7, 8);
        cyc(1, 1, 99);
        cyc(1, 0, 0);
`ifndef HAAR_DWT_ROUND_EN
        check_eq("startdin_a", int'(dout_a), 1);
        check_eq("startdin_d", int'(dout_d), 'hFF);
`endif
        for (int k = 0; k < 3; k++) cyc(1, 0, 0);

        // start pulsed mid-transform is ignored
        for (int i = 0; i < 8; i++) cyc(1, 0, int'($urandom_range(0, 255)));
        cyc(1, 1, 0);
        ndone = 0;
        cyc(1, 0, 0); ndone += int'(done);
        cyc(1, 1, 0); ndone += int'(done);
        cyc(1, 0, 0); ndone += int'(done);
        cyc(1, 0, 0); ndone += int'(done);
        cyc(1, 0, 0); ndone += int'(done);
        cyc(1, 0, 0); ndone += int'(done);
        check_eq("busy_start_ndone", ndone, 1);

        // Reset mid-transform, then a transform over the cleared window
        load(10, 20, 30, 40, 50, 60, 70, 80);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        check_eq("midrst_a", int'(dout_a), 0);
        check_eq("midrst_d", int'(dout_d), 0);
        cyc(1, 1, 0);
        for (int k = 0; k < 4; k++) cyc(1, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
